apb3_simplebus_bridge: RTL and testbench

- APB3 slave that converts each APB3 access into one transaction on the cmd/rsp bus (valid/ready command, valid-only response) used by the on-chip RAM.
- Sits directly upstream of the RAM, between the APB3 decoder and the RAM's bus port.
- Holds the APB access phase (PREADY low) until the command is accepted and, for reads, until the response returns.
- A bounded timeout stops a hung slave from stalling the APB forever.

---
 rtl/apb3_simplebus_bridge.sv | 206 ++++++++++++++++++++
 tb/tb_apb3_simplebus_bridge.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb3_simplebus_bridge.sv
// ---------------------------------------------------------------------------
// apb3_simplebus_bridge
//
// APB3 slave that turns every APB access into exactly one transaction on the
// RAM's cmd/rsp bus (valid/ready command, valid-only response). The APB access
// phase is stretched (PREADY low) until the command is accepted and, for
// reads, until the response data returns. A cycle counter aborts an access
// with PSLVERR when the slave does not complete within TIMEOUT_CYCLES.
//
// Ports:
//   io_mainClk                  clock, rising edge
//   resetCtrl_systemReset       synchronous active-high reset
//   io_apb_PADDR/PSEL/PENABLE/PWRITE/PWDATA   APB3 request
//   io_apb_PREADY/PRDATA/PSLVERR               APB3 completion (registered)
//   io_bus_cmd_valid/ready      command handshake
//   io_bus_cmd_payload_*        command payload (write, address, data, mask)
//   io_bus_rsp_valid/payload_data  read response
// ---------------------------------------------------------------------------
module apb3_simplebus_bridge #(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  io_mainClk,
    input  logic                  resetCtrl_systemReset,
    input  logic [ADDR_WIDTH-1:0] io_apb_PADDR,
    input  logic                  io_apb_PSEL,
    input  logic                  io_apb_PENABLE,
    input  logic                  io_apb_PWRITE,
    input  logic [31:0]           io_apb_PWDATA,
    output logic                  io_apb_PREADY,
    output logic [31:0]           io_apb_PRDATA,
    output logic                  io_apb_PSLVERR,
    output logic                  io_bus_cmd_valid,
    input  logic                  io_bus_cmd_ready,
    output logic                  io_bus_cmd_payload_write,
    output logic [31:0]           io_bus_cmd_payload_address,
    output logic [31:0]           io_bus_cmd_payload_data,
    output logic [3:0]            io_bus_cmd_payload_mask,
    input  logic                  io_bus_rsp_valid,
    input  logic [31:0]           io_bus_rsp_payload_data
);

    // Counter must be able to hold TIMEOUT_CYCLES: a read that fires on the
    // last allowed CMD cycle gets one WAIT_RSP cycle with the count at that value.
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CMD      = 2'd1,
        S_WAIT_RSP = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             pready_q,    pready_d;
    logic [31:0]      prdata_q,    prdata_d;
    logic             pslverr_q,   pslverr_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             write_q,     write_d;
    logic [31:0]      addr_q,      addr_d;
    logic [31:0]      data_q,      data_d;
    logic [3:0]       mask_q,      mask_d;

    logic apb_access_s;
    logic cmd_fire_s;
    logic timeout_s;

    assign apb_access_s = io_apb_PSEL & io_apb_PENABLE;
    assign cmd_fire_s   = cmd_valid_q & io_bus_cmd_ready;
    // The count reaches CNT_LAST in the TIMEOUT_CYCLES-th cycle spent in CMD/WAIT_RSP.
    assign timeout_s    = (cnt_q >= CNT_LAST);

    // State and output/payload registers with synchronous reset.
    always_ff @(posedge io_mainClk) begin
        if (resetCtrl_systemReset) begin
            state_q     <= S_IDLE;
            cnt_q       <= CNT_ZERO;
            pready_q    <= 1'b0;
            prdata_q    <= 32'h0000_0000;
            pslverr_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= 32'h0000_0000;
            data_q      <= 32'h0000_0000;
            mask_q      <= 4'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pready_q    <= pready_d;
            prdata_q    <= prdata_d;
            pslverr_q   <= pslverr_d;
            cmd_valid_q <= cmd_valid_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
        end
    end

    // Next-state logic; a completion in the timeout cycle takes precedence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (apb_access_s) begin
                    state_d = S_CMD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CMD: begin
                if (cmd_fire_s) begin
                    state_d = write_q ? S_DONE : S_WAIT_RSP;
                end else if (timeout_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_CMD;
                end
            end
            S_WAIT_RSP: begin
                if (io_bus_rsp_valid || timeout_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT_RSP;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, payload and timeout counter.
    // PREADY/PSLVERR default low so they are high only in the DONE cycle.
    always_comb begin
        cnt_d       = cnt_q;
        pready_d    = 1'b0;
        pslverr_d   = 1'b0;
        prdata_d    = prdata_q;
        cmd_valid_d = cmd_valid_q;
        write_d     = write_q;
        addr_d      = addr_q;
        data_d      = data_q;
        mask_d      = mask_q;
        case (state_q)
            S_IDLE: begin
                if (apb_access_s) begin
                    cmd_valid_d = 1'b1;
                    write_d     = io_apb_PWRITE;
                    addr_d      = 32'(io_apb_PADDR) & 32'hFFFF_FFFC;
                    data_d      = io_apb_PWDATA;
                    mask_d      = io_apb_PWRITE ? 4'hF : 4'h0;
                    cnt_d       = CNT_ZERO;
                end else begin
                    cmd_valid_d = 1'b0;
                end
            end
            S_CMD: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cmd_fire_s) begin
                    cmd_valid_d = 1'b0;
                    pready_d    = write_q;
                end else if (timeout_s) begin
                    cmd_valid_d = 1'b0;
                    pready_d    = 1'b1;
                    pslverr_d   = 1'b1;
                    prdata_d    = write_q ? prdata_q : 32'h0000_0000;
                end else begin
                    cmd_valid_d = 1'b1;
                end
            end
            S_WAIT_RSP: begin
                cnt_d = cnt_q + CNT_ONE;
                if (io_bus_rsp_valid) begin
                    prdata_d = io_bus_rsp_payload_data;
                    pready_d = 1'b1;
                end else if (timeout_s) begin
                    prdata_d  = 32'h0000_0000;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                end else begin
                    prdata_d = prdata_q;
                end
            end
            S_DONE: begin
                cmd_valid_d = 1'b0;
            end
            default: begin
                cmd_valid_d = 1'b0;
            end
        endcase
    end

    assign io_apb_PREADY              = pready_q;
    assign io_apb_PRDATA              = prdata_q;
    assign io_apb_PSLVERR             = pslverr_q;
    assign io_bus_cmd_valid           = cmd_valid_q;
    assign io_bus_cmd_payload_write   = write_q;
    assign io_bus_cmd_payload_address = addr_q;
    assign io_bus_cmd_payload_data    = data_q;
    assign io_bus_cmd_payload_mask    = mask_q;

endmodule

// File: tb/tb_apb3_simplebus_bridge.sv
// ---------------------------------------------------------------------------
// Testbench for apb3_simplebus_bridge. Inputs are driven and outputs sampled
// on the falling edge. A small RAM slave answers the cmd/rsp bus; expected
// APB results come from a word-array model and latency rules per access.
// ---------------------------------------------------------------------------
module tb_apb3_simplebus_bridge;

    localparam int AW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] paddr;
    logic          psel, penable, pwrite;
    logic [31:0]   pwdata;
    logic          pready;
    logic [31:0]   prdata;
    logic          pslverr;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [31:0]   cmd_addr, cmd_data;
    logic [3:0]    cmd_mask;
    logic          rsp_valid;
    logic [31:0]   rsp_data;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   ram     [256];
    logic [31:0]   ref_mem [256];
    logic [31:0]   exp_prdata;

    always #5 clk = ~clk;

    apb3_simplebus_bridge #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .io_mainClk                 (clk),
        .resetCtrl_systemReset      (rst),
        .io_apb_PADDR               (paddr),
        .io_apb_PSEL                (psel),
        .io_apb_PENABLE             (penable),
        .io_apb_PWRITE              (pwrite),
        .io_apb_PWDATA              (pwdata),
        .io_apb_PREADY              (pready),
        .io_apb_PRDATA              (prdata),
        .io_apb_PSLVERR             (pslverr),
        .io_bus_cmd_valid           (cmd_valid),
        .io_bus_cmd_ready           (cmd_ready),
        .io_bus_cmd_payload_write   (cmd_write),
        .io_bus_cmd_payload_address (cmd_addr),
        .io_bus_cmd_payload_data    (cmd_data),
        .io_bus_cmd_payload_mask    (cmd_mask),
        .io_bus_rsp_valid           (rsp_valid),
        .io_bus_rsp_payload_data    (rsp_data)
    );

    // One APB access. rdly = cycles the slave keeps cmd_ready low while
    // cmd_valid is high; respond = slave returns read data one cycle after fire.
    // Called and returns at a falling edge.
    task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                        input int rdly, input logic respond, input string name);
        int          f_exp, done_exp, vc_exp, k, seen, valid_cycles;
        logic        err_exp, pending, done;
        logic [31:0] prd_exp, addr_exp;
        logic [7:0]  fired_idx;
        // Reference: cycle index 1 is the first cycle after the access phase is seen.
        addr_exp = 32'(addr) & 32'hFFFF_FFFC;
        f_exp    = rdly + 1;
        vc_exp   = (f_exp <= TO) ? f_exp : TO;
        if (wr) begin
            prd_exp = exp_prdata;
            if (f_exp <= TO) begin
                done_exp = f_exp + 1; err_exp = 1'b0; ref_mem[addr[9:2]] = wdata;
            end else begin
                done_exp = TO + 1;    err_exp = 1'b1;
            end
        end else begin
            if (f_exp <= TO && respond) begin
                done_exp = f_exp + 2; err_exp = 1'b0; prd_exp = ref_mem[addr[9:2]];
            end else if (f_exp <= TO) begin
                done_exp = ((f_exp + 1 > TO) ? f_exp + 1 : TO) + 1; err_exp = 1'b1; prd_exp = 32'h0;
            end else begin
                done_exp = TO + 1;    err_exp = 1'b1; prd_exp = 32'h0;
            end
        end
        // Setup phase
        psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wdata;
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0 || pready !== 1'b0) begin
            errors++;
            $display("FAIL %s setup_ignored: cmd_valid=%b pready=%b, required 0 0", name, cmd_valid, pready);
        end
        penable = 1'b1;
        pending = 1'b0; done = 1'b0; seen = 0; valid_cycles = 0; k = 0; fired_idx = 8'h00;
        while (!done && k < TO + 6) begin
            @(negedge clk);
            k++;
            rsp_valid = pending && respond;
            rsp_data  = pending ? ram[fired_idx] : $urandom;
            pending   = 1'b0;
            if (pready === 1'b1) begin
                done = 1'b1; rsp_valid = 1'b0; cmd_ready = 1'b0;
                checks++;
                if (k != done_exp) begin
                    errors++;
                    $display("FAIL %s pready_cycle: got %0d, required %0d", name, k, done_exp);
                end
                checks++;
                if (pslverr !== err_exp || prdata !== prd_exp || cmd_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s completion: pslverr=%b prdata=%h cmd_valid=%b, required %b %h 0",
                             name, pslverr, prdata, cmd_valid, err_exp, prd_exp);
                end
            end else begin
                checks++;
                if (pslverr !== 1'b0) begin
                    errors++;
                    $display("FAIL %s pslverr_idle: got %b, required 0", name, pslverr);
                end
                if (cmd_valid === 1'b1) begin
                    valid_cycles++;
                    checks++;
                    if (cmd_addr !== addr_exp || cmd_write !== wr || cmd_data !== wdata ||
                        cmd_mask !== (wr ? 4'hF : 4'h0)) begin
                        errors++;
                        $display("FAIL %s payload: addr=%h wr=%b data=%h mask=%h, required %h %b %h %h",
                                 name, cmd_addr, cmd_write, cmd_data, cmd_mask,
                                 addr_exp, wr, wdata, (wr ? 4'hF : 4'h0));
                    end
                    if (seen >= rdly) begin
                        cmd_ready = 1'b1;
                        fired_idx = cmd_addr[9:2];
                        if (cmd_write) ram[cmd_addr[9:2]] = cmd_data;
                        else           pending = 1'b1;
                    end else begin
                        cmd_ready = 1'b0;
                    end
                    seen++;
                end else begin
                    cmd_ready = 1'($urandom);
                end
                // APB inputs wander during the access; they must be ignored.
                paddr = AW'($urandom); pwdata = $urandom; pwrite = 1'($urandom);
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s no_pready: waited %0d cycles, required pready at cycle %0d", name, k, done_exp);
        end
        checks++;
        if (valid_cycles != vc_exp) begin
            errors++;
            $display("FAIL %s cmd_valid_cycles: got %0d, required %0d", name, valid_cycles, vc_exp);
        end
        @(negedge clk);
        checks++;
        if (pready !== 1'b0 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s pready_one_cycle: pready=%b cmd_valid=%b, required 0 0", name, pready, cmd_valid);
        end
        psel = 1'b0; penable = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0;
        exp_prdata = prd_exp;
    endtask

    task automatic test_reset();
        rst = 1'b1; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; pwdata = $urandom;
        repeat (3) @(negedge clk);
        checks++;
        if (pready !== 1'b0 || prdata !== 32'h0 || pslverr !== 1'b0) begin
            errors++;
            $display("FAIL reset_apb: pready=%b prdata=%h pslverr=%b, required 0 0 0", pready, prdata, pslverr);
        end
        checks++;
        if (cmd_valid !== 1'b0 || cmd_write !== 1'b0 || cmd_addr !== 32'h0 ||
            cmd_data !== 32'h0 || cmd_mask !== 4'h0) begin
            errors++;
            $display("FAIL reset_bus: valid=%b wr=%b addr=%h data=%h mask=%h, required all 0",
                     cmd_valid, cmd_write, cmd_addr, cmd_data, cmd_mask);
        end
        psel = 1'b0; penable = 1'b0; rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        xfer(1'b1, 16'h0010, 32'h0000_1234, 0, 1'b1, "write_basic");
        ram[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
        xfer(1'b0, 16'h0013, 32'h0, 0, 1'b1, "read_basic");
    endtask

    task automatic test_stall();
        xfer(1'b1, 16'h0024, $urandom, 5, 1'b1, "write_stall5");
        xfer(1'b0, 16'h0024, $urandom, 3, 1'b1, "read_stall3");
    endtask

    task automatic test_timeout();
        xfer(1'b0, 16'h0030, 32'h0, 0, 1'b0, "read_timeout");
        @(negedge clk);
        rsp_valid = 1'b1; rsp_data = 32'hA5A5_5A5A;
        @(negedge clk);
        rsp_valid = 1'b0;
        repeat (3) begin
            checks++;
            if (pready !== 1'b0 || prdata !== exp_prdata || cmd_valid !== 1'b0) begin
                errors++;
                $display("FAIL stray_rsp: pready=%b prdata=%h cmd_valid=%b, required 0 %h 0",
                         pready, prdata, cmd_valid, exp_prdata);
            end
            @(negedge clk);
        end
        xfer(1'b1, 16'h0040, $urandom, TO - 1, 1'b1, "write_fire_at_limit");
        xfer(1'b0, 16'h0040, 32'h0, TO - 1, 1'b1, "read_fire_at_limit");
        xfer(1'b1, 16'h0044, $urandom, TO, 1'b1, "write_timeout");
        xfer(1'b0, 16'h0044, 32'h0, TO - 1, 1'b0, "read_fire_at_limit_norsp");
    endtask

    task automatic test_reset_mid();
        ram[5] = 32'h0BAD_F00D; ref_mem[5] = 32'h0BAD_F00D;
        xfer(1'b0, 16'h0014, 32'h0, 0, 1'b1, "read_before_reset");
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0014;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (pready !== 1'b0 || cmd_valid !== 1'b0 || prdata !== 32'h0 || pslverr !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: pready=%b cmd_valid=%b prdata=%h pslverr=%b, required 0 0 0 0",
                     pready, cmd_valid, prdata, pslverr);
        end
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        exp_prdata = 32'h0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (pready !== 1'b0 || cmd_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_quiet: pready=%b cmd_valid=%b, required 0 0", pready, cmd_valid);
            end
        end
        xfer(1'b0, 16'h0014, 32'h0, 0, 1'b1, "read_after_reset");
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        v = $urandom;
        xfer(1'b1, 16'h0050, v, 0, 1'b1, "b2b_write");
        xfer(1'b0, 16'h0050, 32'h0, 0, 1'b1, "b2b_read");
        xfer(1'b1, 16'h0054, ~v, 1, 1'b1, "b2b_write2");
    endtask

    task automatic test_random();
        int r, rdly;
        for (int i = 0; i < 24; i++) begin
            r    = $urandom_range(0, 9);
            rdly = (r < 7) ? (r % 3) : ((r == 7) ? TO - 1 : TO + 1);
            xfer(1'($urandom), AW'($urandom_range(0, 255)), $urandom, rdly,
                 ($urandom_range(0, 7) != 0), "random");
        end
    endtask

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = 32'h0;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0;
        exp_prdata = 32'h0;
        for (int i = 0; i < 256; i++) begin
            ram[i] = $urandom; ref_mem[i] = ram[i];
        end
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
